// File: rtl/ssd_scan_controller_pkg.sv
// Shared constants and scan state encoding for the seven-segment display controller.
package ssd_scan_controller_pkg;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/ssd_scan_controller_seg.sv
// Hex to seven-segment decoder; segments {g..a}, active-low.
module binaryToSegment
    import ssd_scan_controller_pkg::*;
(
    input  logic [3:0] i_bin,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_bin)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// 4-digit SSD owner: digit register file with sequential write pointer and a
// guard/drive time-multiplexed scan of the anodes.
//   state    | meaning
//   ST_GUARD | all anodes off between digits (anti-ghosting)
//   ST_DRIVE | latched digit shown on its anode, blank if not yet loaded
module ssd_scan_controller
    import ssd_scan_controller_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 500
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic       i_clear,
    input  logic [3:0] i_user_inp,
    output logic [3:0] o_active_digit,
    output logic [6:0] o_seven_out,
    output logic [1:0] o_wr_ptr,
    output logic       o_frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] SLOT_END  = CW'(REFRESH_DIV - 1);

    logic [3:0]    r_digit [4];
    logic [3:0]    r_valid;
    logic [1:0]    r_wr_ptr;

    scan_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_slot_cnt, w_cnt_nxt;
    logic [1:0]    r_scan_idx, w_idx_nxt;
    logic          w_enter_drive;
    logic [3:0]    r_lat_digit, w_lat_digit;
    logic          r_lat_valid, w_lat_valid;
    logic [6:0]    w_seg;
    logic [3:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;

    logic [3:0]    r_active_digit;
    logic [6:0]    r_seven_out;
    logic          r_frame_start;

    // clear has priority and drops a coincident load
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) r_digit[i] <= 4'h0;
            r_valid  <= 4'b0000;
            r_wr_ptr <= 2'd0;
        end else if (i_clear) begin
            r_valid  <= 4'b0000;
            r_wr_ptr <= 2'd0;
        end else if (i_load) begin
            r_digit[r_wr_ptr] <= i_user_inp;
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + 2'd1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_slot_cnt + CW'(1);
        w_idx_nxt     = r_scan_idx;
        w_enter_drive = 1'b0;
        case (r_state)
            ST_GUARD: begin
                if (r_slot_cnt == GUARD_END) begin
                    w_state_nxt   = ST_DRIVE;
                    w_enter_drive = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (r_slot_cnt == SLOT_END) begin
                    w_state_nxt = ST_GUARD;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_scan_idx + 2'd1;
                end
            end
            default: w_state_nxt = ST_GUARD;
        endcase
    end

    // Snapshot taken only on DRIVE entry so writes never disturb a slot in progress.
    always_comb begin
        w_lat_digit = r_lat_digit;
        w_lat_valid = r_lat_valid;
        if (w_enter_drive) begin
            w_lat_digit = r_digit[r_scan_idx];
            w_lat_valid = r_valid[r_scan_idx];
        end
    end

    binaryToSegment u_seg (
        .i_bin (w_lat_digit),
        .o_seg (w_seg)
    );

    always_comb begin
        w_an_nxt  = ANODE_OFF;
        w_seg_nxt = SEG_OFF;
        if (w_state_nxt == ST_DRIVE && w_lat_valid) begin
            w_an_nxt  = ~(4'b0001 << r_scan_idx);
            w_seg_nxt = w_seg;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_GUARD;
            r_slot_cnt     <= '0;
            r_scan_idx     <= 2'd0;
            r_lat_digit    <= 4'h0;
            r_lat_valid    <= 1'b0;
            r_active_digit <= ANODE_OFF;
            r_seven_out    <= SEG_OFF;
            r_frame_start  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_slot_cnt     <= w_cnt_nxt;
            r_scan_idx     <= w_idx_nxt;
            r_lat_digit    <= w_lat_digit;
            r_lat_valid    <= w_lat_valid;
            r_active_digit <= w_an_nxt;
            r_seven_out    <= w_seg_nxt;
            r_frame_start  <= w_enter_drive && (r_scan_idx == 2'd0);
        end
    end

    assign o_active_digit = r_active_digit;
    assign o_seven_out    = r_seven_out;
    assign o_wr_ptr       = r_wr_ptr;
    assign o_frame_start  = r_frame_start;

endmodule
